acc_cpu_core: RTL and testbench
===============================

# acc_cpu_core

Parametrised accumulator CPU core: 3-bit opcode plus ADDR_WIDTH operand, with internal instruction and data memories, a 3-cycle fetch/decode/execute FSM and an accumulator of DATA_WIDTH bits. It generalises the fixed 8-bit/5-bit accumulator CPU. New features are a carry flag, a retired-instruction counter, resume-from-halt, and a program/debug port for loading and reading memories without hierarchical access. The block is the top-level compute unit, and the test bench drives it directly.

## Interface
- DATA_WIDTH, 8, accumulator and data-memory word width
- ADDR_WIDTH, 5, operand/PC width; both memories have 2**ADDR_WIDTH words; instruction word = 3+ADDR_WIDTH bits
- CNT_WIDTH, 16, retired-instruction counter width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset
- resume  input  1  leave HALTED state (sampled only in HALTED)
- prog_we  input  1  memory write strobe from program/debug port
- prog_sel  input  1  0 = instruction memory, 1 = data memory
- prog_addr  input  ADDR_WIDTH  program/debug address
- prog_wdata  input  max(3+ADDR_WIDTH, DATA_WIDTH)  write data, LSB-aligned
- dbg_rdata  output  max(3+ADDR_WIDTH, DATA_WIDTH)  registered read of selected memory at prog_addr, zero-extended
- HALT  output  1  high while in HALTED
- acc  output  DATA_WIDTH  accumulator
- pc  output  ADDR_WIDTH  program counter
- carry  output  1  carry out of last ADD
- retired  output  CNT_WIDTH  instructions completed since reset, saturating

## Operation
- Opcodes [top 3 bits]: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7; operand = low ADDR_WIDTH bits.
- States: FETCH, DECODE, EXEC, HALTED.
- FETCH: ir <= imem[pc]; pc <= pc+1 (wraps to 0 from 2**ADDR_WIDTH-1). Next state is DECODE.
- DECODE: dbuf <= dmem[operand] (always read, used or not). Next state is EXEC.
- EXEC, by opcode:
  - HLT -> HALTED.
  - SKZ: if acc==0, pc <= pc+1 (wraps).
  - ADD: {carry,acc} <= acc+dbuf, DATA_WIDTH+1 bits.
  - AND / XOR: acc <= acc op dbuf.
  - LDA: acc <= dbuf.
  - STO: dmem[operand] <= acc.
  - JMP: pc <= operand.
  - Every opcode except HLT -> FETCH. carry changes only on ADD.
- retired increments in EXEC for every opcode including HLT; it saturates at all-ones.
- HALTED: pc points past the HLT. resume=1 -> FETCH on the next edge; otherwise stay.
- Program port:
  - prog_we is honoured only while rst==0 or state==HALTED; ignored while running, so there is no conflict with STO.
  - prog_we together with resume in HALTED: both take effect on the same edge.
- dbg_rdata = mem[prog_sel][prog_addr] registered every cycle, in any state. The memory needs an independent read port from the core's own read.
- Reset values (rst==0 at an edge):
  - pc=0, acc=0, ir=0, carry=0, retired=0, dbg_rdata=0, state=FETCH, HALT=0.
  - Memory contents are preserved.

## Timing
- Each instruction takes exactly 3 cycles: FETCH, DECODE, EXEC. No pipelining.
- Edge numbering: E1 is the first rising edge with rst==1 after reset.
  - The instruction at address 0 executes on E1–E3.
  - Instruction k (sequential, no skips) completes at E(3k+3).
- HALT rises on the edge that executes the HLT EXEC and is visible after that edge. It falls one edge after resume is sampled.
- acc, carry, pc and the dmem write become visible after the EXEC edge.
- dbg_rdata latency is 1 cycle.
- Reset mid-instruction: the in-flight instruction is abandoned. A STO whose EXEC edge coincides with rst==0 does not write.
- Read-after-STO to the same address in the next instruction returns the new value.

## Test plan
- Reset/HLT: imem[0]=HLT, pulse rst low one cycle -> HALT=0 after E1 and E2; HALT=1 after E3; pc=1; retired=1; stays halted for 5 further edges.
- JMP: imem[0]=JMP 2, imem[1]=JMP 2, imem[2]=HLT -> HALT=1 after E6, pc=3, retired=2.
- SKZ: imem[0]=SKZ, imem[1]=JMP 1, imem[2]=HLT, acc=0 after reset -> HALT=1 after E6. Repeat with imem[0]=LDA 4 (dmem[4]=1), SKZ, JMP 3, HLT -> HALT=1 after E12.
- LDA/STO via program port:
  - Load dmem[5]=18 and imem LDA 5, STO 10, HLT during reset.
  - Expect acc=18 after E3 and HALT after E9.
  - Then set prog_sel=1, prog_addr=10 -> dbg_rdata=18 one cycle later.
- ADD carry (DATA_WIDTH=8): dmem[1]=200, dmem[2]=100; program LDA 1, ADD 2, HLT -> acc=44, carry=1.
- Resume and guard:
  - After HALT, prog_we writes imem[pc]=HLT together with resume=1 -> the core re-halts 3 edges later with retired incremented by 1.
  - A prog_we to dmem while running is ignored: dbg_rdata is unchanged.

Source files
------------

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: parametrised 3-cycle accumulator CPU with internal memories and program/debug port
// Ports: clk, rst (sync, active-low); resume leaves HALTED; prog_we/prog_sel/prog_addr/prog_wdata
// load imem (sel=0) or dmem (sel=1) during reset or halt; dbg_rdata is a registered read of the
// selected memory; HALT, acc, pc, carry, retired expose core state.
module acc_cpu_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH = 16,
  localparam int IW = 3 + ADDR_WIDTH,
  localparam int PW = IW > DATA_WIDTH ? IW : DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  resume,
  input  logic                  prog_we,
  input  logic                  prog_sel,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [PW-1:0]         prog_wdata,
  output logic [PW-1:0]         dbg_rdata,
  output logic                  HALT,
  output logic [DATA_WIDTH-1:0] acc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  carry,
  output logic [CNT_WIDTH-1:0]  retired
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALTED} state_t;
  typedef enum logic [2:0] {OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP} op_t;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] dbuf_q, dbuf_d, acc_q, acc_d;
  logic carry_q, carry_d, halt_q, halt_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic [PW-1:0] dbg_q, dbg_d;
  logic [IW-1:0] imem [DEPTH];
  logic [DATA_WIDTH-1:0] dmem [DEPTH];
  op_t op;
  logic [ADDR_WIDTH-1:0] opnd, dmem_wa;
  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH-1:0] dmem_wd;
  logic prog_ok, sto, imem_we, dmem_we;
  assign op = op_t'(ir_q[IW-1 -: 3]);
  assign opnd = ir_q[ADDR_WIDTH-1:0];
  assign sum = {1'b0, acc_q} + {1'b0, dbuf_q};
  // The port may only touch memory when the core cannot, so STO never collides with it.
  assign prog_ok = !rst || state_q == HALTED;
  assign sto = rst && state_q == EXEC && op == OP_STO;
  assign imem_we = prog_we && prog_ok && !prog_sel;
  assign dmem_we = sto || (prog_we && prog_ok && prog_sel);
  assign dmem_wa = sto ? opnd : prog_addr;
  assign dmem_wd = sto ? acc_q : prog_wdata[DATA_WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    dbuf_d = dbuf_q;
    acc_d = acc_q;
    carry_d = carry_q;
    retired_d = retired_q;
    dbg_d = prog_sel ? PW'(dmem[prog_addr]) : PW'(imem[prog_addr]);
    unique case (state_q)
      FETCH: begin
        ir_d = imem[pc_q];
        pc_d = pc_q + 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        dbuf_d = dmem[opnd];
        state_d = EXEC;
      end
      EXEC: begin
        retired_d = retired_q + {{(CNT_WIDTH-1){1'b0}}, ~&retired_q};
        state_d = op == OP_HLT ? HALTED : FETCH;
        pc_d = op == OP_JMP ? opnd : (op == OP_SKZ && acc_q == '0) ? pc_q + 1'b1 : pc_q;
        acc_d = op == OP_ADD ? sum[DATA_WIDTH-1:0] :
                op == OP_AND ? acc_q & dbuf_q :
                op == OP_XOR ? acc_q ^ dbuf_q :
                op == OP_LDA ? dbuf_q : acc_q;
        carry_d = op == OP_ADD ? sum[DATA_WIDTH] : carry_q;
      end
      HALTED: state_d = resume ? FETCH : HALTED;
    endcase
    halt_d = state_d == HALTED;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q <= '0;
      ir_q <= '0;
      dbuf_q <= '0;
      acc_q <= '0;
      carry_q <= 1'b0;
      retired_q <= '0;
      dbg_q <= '0;
      halt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      dbuf_q <= dbuf_d;
      acc_q <= acc_d;
      carry_q <= carry_d;
      retired_q <= retired_d;
      dbg_q <= dbg_d;
      halt_q <= halt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (imem_we) imem[prog_addr] <= prog_wdata[IW-1:0];
    if (dmem_we) dmem[dmem_wa] <= dmem_wd;
  end
  assign dbg_rdata = dbg_q;
  assign HALT = halt_q;
  assign acc = acc_q;
  assign pc = pc_q;
  assign carry = carry_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core: table, directed and randomized checks of acc_cpu_core against a behavioural model
module tb_acc_cpu_core;
  localparam int AW = 5, N = 32, CW = 16;
  localparam logic [7:0] H = 8'h00;
  logic clk = 0, rst = 0, resume = 0, prog_we = 0, prog_sel = 0;
  logic [AW-1:0] prog_addr = '0;
  logic [7:0] prog_wdata = '0;
  logic [7:0] dbg_rdata, acc, dbg2, acc2;
  logic HALT, carry, halt2, carry2;
  logic [AW-1:0] pc, pc2;
  logic [CW-1:0] retired;
  logic [1:0] ret2;
  int checks = 0, failures = 0;
  logic [7:0] im [N];
  logic [7:0] dm [N];
  acc_cpu_core #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .resume(resume), .prog_we(prog_we), .prog_sel(prog_sel),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .dbg_rdata(dbg_rdata), .HALT(HALT),
    .acc(acc), .pc(pc), .carry(carry), .retired(retired));
  acc_cpu_core #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .resume(resume), .prog_we(prog_we), .prog_sel(prog_sel),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .dbg_rdata(dbg2), .HALT(halt2),
    .acc(acc2), .pc(pc2), .carry(carry2), .retired(ret2));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] p [8];
    logic [7:0] d [8];
    int edges;
    logic [7:0] acc;
    logic c;
    int pc;
    int ret;
    int da;
    logic [7:0] dv;
  } vec_t;
  vec_t v [9];
  function automatic logic [7:0] ins(int op, int a);
    return {op[2:0], a[4:0]};
  endfunction
  task automatic chk(string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic clear_mem();
    for (int i = 0; i < N; i++) begin
      im[i] = H;
      dm[i] = 8'd0;
    end
  endtask
  task automatic load();
    @(negedge clk);
    rst = 0;
    resume = 0;
    for (int i = 0; i < 2 * N; i++) begin
      prog_we = 1;
      prog_sel = i >= N;
      prog_addr = AW'(i % N);
      prog_wdata = i < N ? im[i] : dm[i - N];
      @(negedge clk);
    end
    prog_we = 0;
    rst = 1;
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic run_halt(output int e);
    e = 0;
    while (e < 500) begin
      step(1);
      e++;
      if (HALT) break;
    end
  endtask
  int e, mpc, macc, mc, mret, halted, a, s;
  logic [7:0] ir;
  initial begin
    v[0] = '{p:'{ins(0,0),H,H,H,H,H,H,H}, d:'{default:8'd0}, edges:3, acc:8'd0, c:1'b0, pc:1, ret:1, da:0, dv:8'd0};
    v[1] = '{p:'{ins(7,2),ins(7,2),ins(0,0),H,H,H,H,H}, d:'{default:8'd0}, edges:6, acc:8'd0, c:1'b0, pc:3, ret:2, da:0, dv:8'd0};
    v[2] = '{p:'{ins(1,0),ins(7,1),ins(0,0),H,H,H,H,H}, d:'{default:8'd0}, edges:6, acc:8'd0, c:1'b0, pc:3, ret:2, da:0, dv:8'd0};
    v[3] = '{p:'{ins(5,4),ins(1,0),ins(7,3),ins(0,0),H,H,H,H}, d:'{8'd0,8'd0,8'd0,8'd0,8'd1,8'd0,8'd0,8'd0}, edges:12, acc:8'd1, c:1'b0, pc:4, ret:4, da:4, dv:8'd1};
    v[4] = '{p:'{ins(5,1),ins(2,2),ins(0,0),H,H,H,H,H}, d:'{8'd0,8'd200,8'd100,8'd0,8'd0,8'd0,8'd0,8'd0}, edges:9, acc:8'd44, c:1'b1, pc:3, ret:3, da:2, dv:8'd100};
    v[5] = '{p:'{ins(5,5),ins(6,10),ins(0,0),H,H,H,H,H}, d:'{8'd0,8'd0,8'd0,8'd0,8'd0,8'd18,8'd0,8'd0}, edges:9, acc:8'd18, c:1'b0, pc:3, ret:3, da:10, dv:8'd18};
    v[6] = '{p:'{ins(5,1),ins(3,2),ins(4,3),ins(6,7),ins(0,0),H,H,H}, d:'{8'd0,8'hF0,8'h3C,8'hFF,8'd0,8'd0,8'd0,8'd0}, edges:15, acc:8'hCF, c:1'b0, pc:5, ret:5, da:7, dv:8'hCF};
    v[7] = '{p:'{ins(5,1),ins(2,1),ins(5,2),ins(0,0),H,H,H,H}, d:'{8'd0,8'h80,8'h05,8'd0,8'd0,8'd0,8'd0,8'd0}, edges:12, acc:8'd5, c:1'b1, pc:4, ret:4, da:1, dv:8'h80};
    v[8] = '{p:'{ins(5,1),ins(2,1),ins(2,2),ins(0,0),H,H,H,H}, d:'{8'd0,8'hFF,8'h01,8'd0,8'd0,8'd0,8'd0,8'd0}, edges:12, acc:8'hFF, c:1'b0, pc:4, ret:4, da:2, dv:8'h01};
    for (int k = 0; k < 9; k++) begin
      clear_mem();
      for (int i = 0; i < 8; i++) begin
        im[i] = v[k].p[i];
        dm[i] = v[k].d[i];
      end
      load();
      run_halt(e);
      chk($sformatf("v%0d_edges", k), e, v[k].edges);
      chk($sformatf("v%0d_acc", k), acc, v[k].acc);
      chk($sformatf("v%0d_carry", k), carry, v[k].c);
      chk($sformatf("v%0d_pc", k), pc, v[k].pc);
      chk($sformatf("v%0d_retired", k), retired, v[k].ret);
      prog_sel = 1;
      prog_addr = AW'(v[k].da);
      step(1);
      chk($sformatf("v%0d_dbg", k), dbg_rdata, v[k].dv);
    end
    clear_mem();
    im[1] = ins(7, 0);
    load();
    chk("rst_halt", HALT, 0);
    chk("rst_acc", acc, 0);
    step(1);
    chk("e1_halt", HALT, 0);
    step(1);
    chk("e2_halt", HALT, 0);
    step(1);
    chk("e3_halt", HALT, 1);
    chk("e3_pc", pc, 1);
    chk("e3_retired", retired, 1);
    step(5);
    chk("stay_halt", HALT, 1);
    chk("stay_pc", pc, 1);
    chk("stay_retired", retired, 1);
    resume = 1;
    prog_we = 1;
    prog_sel = 0;
    prog_addr = 5'd1;
    prog_wdata = ins(0, 0);
    step(1);
    resume = 0;
    prog_we = 0;
    chk("resume_fall", HALT, 0);
    step(2);
    chk("rehalt_early", HALT, 0);
    step(1);
    chk("rehalt", HALT, 1);
    chk("rehalt_retired", retired, 2);
    chk("rehalt_pc", pc, 2);
    clear_mem();
    im[0] = ins(7, 0);
    dm[6] = 8'h11;
    load();
    prog_we = 1;
    prog_sel = 1;
    prog_addr = 5'd6;
    prog_wdata = 8'h55;
    step(6);
    prog_we = 0;
    step(1);
    chk("guard_dbg", dbg_rdata, 8'h11);
    chk("guard_running", HALT, 0);
    clear_mem();
    im[0] = ins(5, 5);
    im[1] = ins(6, 10);
    dm[5] = 8'd18;
    load();
    step(5);
    rst = 0;
    step(1);
    chk("midrst_acc", acc, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_dbg", dbg_rdata, 0);
    prog_we = 1;
    prog_sel = 0;
    prog_addr = 5'd0;
    prog_wdata = ins(0, 0);
    step(1);
    prog_we = 0;
    rst = 1;
    prog_sel = 1;
    prog_addr = 5'd10;
    step(1);
    chk("midrst_sto", dbg_rdata, 0);
    clear_mem();
    im[0] = ins(7, 31);
    im[31] = ins(1, 0);
    im[1] = ins(0, 0);
    load();
    run_halt(e);
    chk("wrap_edges", e, 9);
    chk("wrap_pc", pc, 2);
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) begin
        im[i] = ins($urandom_range(15) == 0 ? 0 : $urandom_range(7, 1), $urandom_range(31));
        dm[i] = 8'($urandom);
      end
      load();
      mpc = 0; macc = 0; mc = 0; mret = 0; halted = 0;
      for (int n = 0; n < 40; n++) begin
        if (halted != 0) begin
          resume = 1;
          if ($urandom_range(1) == 1) begin
            prog_we = 1;
            prog_sel = 0;
            prog_addr = AW'(mpc);
            prog_wdata = ins($urandom_range(7), $urandom_range(31));
            im[mpc] = prog_wdata;
          end
          step(1);
          resume = 0;
          prog_we = 0;
          chk("rnd_resume", HALT, 0);
          halted = 0;
        end
        ir = im[mpc];
        a = int'(ir[4:0]);
        mpc = (mpc + 1) % N;
        case (ir[7:5])
          3'd0: halted = 1;
          3'd1: if (macc == 0) mpc = (mpc + 1) % N;
          3'd2: begin s = macc + int'(dm[a]); mc = s / 256; macc = s % 256; end
          3'd3: macc = macc & int'(dm[a]);
          3'd4: macc = macc ^ int'(dm[a]);
          3'd5: macc = int'(dm[a]);
          3'd6: dm[a] = 8'(macc);
          default: mpc = a;
        endcase
        mret++;
        step(3);
        chk("rnd_acc", acc, macc);
        chk("rnd_carry", carry, mc);
        chk("rnd_pc", pc, mpc);
        chk("rnd_halt", HALT, halted);
        chk("rnd_retired", retired, mret);
        chk("rnd_sat", ret2, mret > 3 ? 3 : mret);
      end
      a = $urandom_range(31);
      prog_sel = 1;
      prog_addr = AW'(a);
      step(1);
      chk("rnd_dbg", dbg_rdata, dm[a]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
